// File: rtl/instr_decode_stage_pkg.sv
// Shared types for the decode stage: opcodes, decoded record layout, skid occupancy.
// Pure declarations; no timing or backpressure of its own.
package instr_decode_stage_pkg;

    localparam int WORD_W = 32;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    typedef enum logic [7:0] {
        UNKNOWN = 8'd0,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } instr_name_e;

    typedef enum logic [2:0] {
        XX = 3'd0, AL, BR, LS, MD, RB
    } instr_type_e;

    typedef struct packed {
        logic writes;
        logic jumps;
        logic uses_imm;
        logic tag;
        logic mem;
    } flag_vector_t;

    typedef struct packed {
        logic [5:0] rd;
        logic [5:0] rs_1;
        logic [5:0] rs_2;
        logic [5:0] rn;
    } registers_t;

    typedef struct packed {
        instr_name_e       name;
        instr_type_e       itype;
        flag_vector_t      flags;
        registers_t        regs;
        logic [WORD_W-1:0] imm;
        logic [WORD_W-1:0] address;
    } decoded_instr_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/instr_decode_stage_decoder.sv
// Combinational RV32IM+Zicsr word -> decoded record; zero latency, no flow control.
// Illegal encodings collapse to an all-zero UNKNOWN record that still carries the PC.
module instr_decoder
    import instr_decode_stage_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic [WORD_W-1:0] address,
    output decoded_instr_t    dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt, imm_csr, imm_zimm;

    assign opcode    = instr[6:0];
    assign rd_f      = instr[11:7];
    assign funct3    = instr[14:12];
    assign rs1_f     = instr[19:15];
    assign rs2_f     = instr[24:20];
    assign funct7    = instr[31:25];

    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {instr[31:12], 12'b0};
    assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_shamt = {27'b0, instr[24:20]};
    assign imm_csr   = {20'b0, instr[31:20]};
    assign imm_zimm  = {27'b0, instr[19:15]};

    instr_name_e name;
    instr_type_e itype;
    logic        use_rd, use_rs1, use_rs2, uses_imm, is_mem;
    logic [31:0] imm_v;

    always_comb begin
        name     = UNKNOWN;
        itype    = XX;
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        uses_imm = 1'b0;
        is_mem   = 1'b0;
        imm_v    = '0;
        unique case (opcode)
            OPC_LUI:   begin name = LUI;   itype = AL; use_rd = 1'b1; uses_imm = 1'b1; imm_v = imm_u; end
            OPC_AUIPC: begin name = AUIPC; itype = AL; use_rd = 1'b1; uses_imm = 1'b1; imm_v = imm_u; end
            OPC_JAL:   begin name = JAL;   itype = BR; use_rd = 1'b1; uses_imm = 1'b1; imm_v = imm_j; end
            OPC_JALR: if (funct3 == 3'b000) begin
                name = JALR; itype = BR; use_rd = 1'b1; use_rs1 = 1'b1; uses_imm = 1'b1; imm_v = imm_i;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000: name = BEQ;
                    3'b001: name = BNE;
                    3'b100: name = BLT;
                    3'b101: name = BGE;
                    3'b110: name = BLTU;
                    3'b111: name = BGEU;
                    default: name = UNKNOWN;
                endcase
                itype = BR; use_rs1 = 1'b1; use_rs2 = 1'b1; uses_imm = 1'b1; imm_v = imm_b;
            end
            OPC_LOAD: begin
                case (funct3)
                    3'b000: name = LB;
                    3'b001: name = LH;
                    3'b010: name = LW;
                    3'b100: name = LBU;
                    3'b101: name = LHU;
                    default: name = UNKNOWN;
                endcase
                itype = LS; use_rd = 1'b1; use_rs1 = 1'b1; uses_imm = 1'b1; is_mem = 1'b1; imm_v = imm_i;
            end
            OPC_STORE: begin
                case (funct3)
                    3'b000: name = SB;
                    3'b001: name = SH;
                    3'b010: name = SW;
                    default: name = UNKNOWN;
                endcase
                itype = LS; use_rs1 = 1'b1; use_rs2 = 1'b1; uses_imm = 1'b1; is_mem = 1'b1; imm_v = imm_s;
            end
            OPC_OP_IMM: begin
                imm_v = imm_i;
                case (funct3)
                    3'b000: name = ADDI;
                    3'b010: name = SLTI;
                    3'b011: name = SLTIU;
                    3'b100: name = XORI;
                    3'b110: name = ORI;
                    3'b111: name = ANDI;
                    // funct7 checks also reject shamt[5]=1
                    3'b001: begin
                        imm_v = imm_shamt;
                        if (funct7 == 7'b0000000) name = SLLI;
                    end
                    default: begin
                        imm_v = imm_shamt;
                        if (funct7 == 7'b0000000)      name = SRLI;
                        else if (funct7 == 7'b0100000) name = SRAI;
                    end
                endcase
                itype = AL; use_rd = 1'b1; use_rs1 = 1'b1; uses_imm = 1'b1;
            end
            OPC_OP: begin
                itype = AL; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (funct7 == 7'b0000001) begin
                    itype = MD;
                    case (funct3)
                        3'b000: name = MUL;
                        3'b001: name = MULH;
                        3'b010: name = MULHSU;
                        3'b011: name = MULHU;
                        3'b100: name = DIV;
                        3'b101: name = DIVU;
                        3'b110: name = REM;
                        default: name = REMU;
                    endcase
                end else if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: name = ADD;
                        3'b001: name = SLL;
                        3'b010: name = SLT;
                        3'b011: name = SLTU;
                        3'b100: name = XOR;
                        3'b101: name = SRL;
                        3'b110: name = OR;
                        default: name = AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      name = SUB;
                    else if (funct3 == 3'b101) name = SRA;
                end
            end
            OPC_MISC_MEM: if (funct3 == 3'b000) begin
                name = FENCE; itype = RB;
            end
            OPC_SYSTEM: begin
                itype = RB;
                case (funct3)
                    3'b000: begin
                        if (instr == 32'h0000_0073)      name = ECALL;
                        else if (instr == 32'h0010_0073) name = EBREAK;
                    end
                    3'b001: begin name = CSRRW; use_rd = 1'b1; use_rs1 = 1'b1; imm_v = imm_csr; end
                    3'b010: begin name = CSRRS; use_rd = 1'b1; use_rs1 = 1'b1; imm_v = imm_csr; end
                    3'b011: begin name = CSRRC; use_rd = 1'b1; use_rs1 = 1'b1; imm_v = imm_csr; end
                    3'b101: begin name = CSRRWI; use_rd = 1'b1; uses_imm = 1'b1; imm_v = imm_zimm; end
                    3'b110: begin name = CSRRSI; use_rd = 1'b1; uses_imm = 1'b1; imm_v = imm_zimm; end
                    3'b111: begin name = CSRRCI; use_rd = 1'b1; uses_imm = 1'b1; imm_v = imm_zimm; end
                    default: name = UNKNOWN;
                endcase
            end
            default: name = UNKNOWN;
        endcase

        dec                = '0;
        dec.address        = address;
        if (name != UNKNOWN) begin
            dec.name           = name;
            dec.itype          = itype;
            dec.flags.writes   = use_rd && (rd_f != 5'd0);
            dec.flags.jumps    = (itype == BR);
            dec.flags.uses_imm = uses_imm;
            dec.flags.mem      = is_mem;
            dec.regs.rd        = use_rd  ? {1'b0, rd_f}  : 6'd0;
            dec.regs.rs_1      = use_rs1 ? {1'b0, rs1_f} : 6'd0;
            dec.regs.rs_2      = use_rs2 ? {1'b0, rs2_f} : 6'd0;
            dec.imm            = imm_v;
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode pipeline stage: 1-cycle registered latency into a 2-entry skid buffer.
// Backpressure: ready_out is a flop (low only when both entries full), never combinational on ready_in.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] address_in,
    input  logic            valid_in,
    output logic            ready_out,
    output logic            valid_out,
    input  logic            ready_in,
    output instr_name_e     instr_name,
    output instr_type_e     instr_type,
    output flag_vector_t    flags,
    output registers_t      regs,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] address_out
);

    decoded_instr_t dec;
    decoded_instr_t head_q, head_d;
    decoded_instr_t tail_q, tail_d;
    occ_e           occ_q, occ_d;
    logic           ready_q, ready_d;
    logic           accept, dispatch;

    instr_decoder u_decoder (
        .instr   (instr_in),
        .address (address_in),
        .dec     (dec)
    );

    assign valid_out   = (occ_q != OCC_EMPTY);
    assign ready_out   = ready_q;
    assign instr_name  = head_q.name;
    assign instr_type  = head_q.itype;
    assign flags       = head_q.flags;
    assign regs        = head_q.regs;
    assign imm         = head_q.imm;
    assign address_out = head_q.address;

    assign accept   = valid_in && ready_q;
    assign dispatch = valid_out && ready_in;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case (occ_q)
            OCC_EMPTY: if (accept) begin
                head_d = dec;
                occ_d  = OCC_ONE;
            end
            OCC_ONE: begin
                if (accept && dispatch) begin
                    head_d = dec;
                end else if (accept) begin
                    tail_d = dec;
                    occ_d  = OCC_TWO;
                end else if (dispatch) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_TWO: if (dispatch) begin
                head_d = tail_q;
                occ_d  = OCC_ONE;
            end
            default: occ_d = OCC_EMPTY;
        endcase
        if (flush) begin
            occ_d = OCC_EMPTY;
        end
        ready_d = (int'(occ_d) < SKID_DEPTH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= OCC_EMPTY;
            ready_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: driver queues hand-computed records, monitor pops on dispatch.
module tb_instr_decode_stage;
    import instr_decode_stage_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic [31:0]  instr_in = '0;
    logic [31:0]  address_in = '0;
    logic         valid_in = 1'b0;
    logic         ready_out;
    logic         valid_out;
    logic         ready_in = 1'b0;
    instr_name_e  instr_name;
    instr_type_e  instr_type;
    flag_vector_t flags;
    registers_t   regs;
    logic [31:0]  imm;
    logic [31:0]  address_out;

    instr_decode_stage dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .instr_in    (instr_in),
        .address_in  (address_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .instr_name  (instr_name),
        .instr_type  (instr_type),
        .flags       (flags),
        .regs        (regs),
        .imm         (imm),
        .address_out (address_out)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    decoded_instr_t exp_q[$];

    typedef struct {
        logic [31:0]    w;
        logic [31:0]    a;
        decoded_instr_t e;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic decoded_instr_t mk(input instr_name_e n, input instr_type_e t, input logic [4:0] f,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] im, input logic [31:0] ad);
        decoded_instr_t r;
        r.name    = n;
        r.itype   = t;
        r.flags   = flag_vector_t'(f);
        r.regs    = '{rd: {1'b0, rd}, rs_1: {1'b0, rs1}, rs_2: {1'b0, rs2}, rn: 6'd0};
        r.imm     = im;
        r.address = ad;
        return r;
    endfunction

    // flags literal order: {writes, jumps, uses_imm, tag, mem}
    function automatic vec_t mv(input logic [31:0] w, input logic [31:0] a, input instr_name_e n,
                                input instr_type_e t, input logic [4:0] f, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] im);
        vec_t v;
        v.w = w;
        v.a = a;
        v.e = mk(n, t, f, rd, rs1, rs2, im, a);
        return v;
    endfunction

    // Monitor: compare head on every dispatch; also require the head to hold while stalled.
    logic           stall_prev = 1'b0;
    decoded_instr_t prev_head;
    always @(negedge clock) begin
        decoded_instr_t act;
        act.name    = instr_name;
        act.itype   = instr_type;
        act.flags   = flags;
        act.regs    = regs;
        act.imm     = imm;
        act.address = address_out;
        if (reset || flush) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && valid_out) chk("hold_stable", act, prev_head);
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0h expected none", act);
                end else begin
                    chk("dispatch", act, exp_q.pop_front());
                end
            end
            stall_prev = valid_out && !ready_in;
            prev_head  = act;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input vec_t v, input logic rin);
        bit done = 1'b0;
        valid_in   = 1'b1;
        instr_in   = v.w;
        address_in = v.a;
        ready_in   = rin;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clock);
            if (ready_out) begin
                exp_q.push_back(v.e);
                done = 1'b1;
            end
            step();
        end
        valid_in = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got ready_out=0 for %0h required acceptance", v.w);
        end
    endtask

    task automatic drain();
        bit empty = 1'b0;
        ready_in = 1'b1;
        valid_in = 1'b0;
        for (int t = 0; t < 30 && !empty; t++) begin
            @(negedge clock);
            if (exp_q.size() == 0) empty = 1'b1;
            step();
        end
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
        @(negedge clock);
        chk("drain_valid_low", 128'(valid_out), 128'd0);
        step();
    endtask

    initial begin
        vecs[0]  = mv(32'h0050_0093, 32'h0000_1000, ADDI,    AL, 5'b10100, 5'd1,  5'd0,  5'd0, 32'd5);
        vecs[1]  = mv(32'hFE20_8EE3, 32'h0000_0100, BEQ,     BR, 5'b01100, 5'd0,  5'd1,  5'd2, 32'hFFFF_FFFC);
        vecs[2]  = mv(32'h0220_81B3, 32'h0000_1008, MUL,     MD, 5'b10000, 5'd3,  5'd1,  5'd2, 32'd0);
        vecs[3]  = mv(32'hFFFF_FFFF, 32'h0000_100C, UNKNOWN, XX, 5'b00000, 5'd0,  5'd0,  5'd0, 32'd0);
        vecs[4]  = mv(32'h0081_2283, 32'h0000_1010, LW,      LS, 5'b10101, 5'd5,  5'd2,  5'd0, 32'd8);
        vecs[5]  = mv(32'hFE61_2E23, 32'h0000_1014, SW,      LS, 5'b00101, 5'd0,  5'd2,  5'd6, 32'hFFFF_FFFC);
        vecs[6]  = mv(32'h1234_53B7, 32'h0000_1018, LUI,     AL, 5'b10100, 5'd7,  5'd0,  5'd0, 32'h1234_5000);
        vecs[7]  = mv(32'h4034_D413, 32'h0000_101C, SRAI,    AL, 5'b10100, 5'd8,  5'd9,  5'd0, 32'd3);
        vecs[8]  = mv(32'h0200_9093, 32'h0000_1020, UNKNOWN, XX, 5'b00000, 5'd0,  5'd0,  5'd0, 32'd0);
        vecs[9]  = mv(32'h0080_00EF, 32'h0000_1024, JAL,     BR, 5'b11100, 5'd1,  5'd0,  5'd0, 32'd8);
        vecs[10] = mv(32'h3005_9573, 32'h0000_1028, CSRRW,   RB, 5'b10000, 5'd10, 5'd11, 5'd0, 32'h300);
        vecs[11] = mv(32'h3052_E073, 32'h0000_102C, CSRRSI,  RB, 5'b00100, 5'd0,  5'd0,  5'd0, 32'd5);
        vecs[12] = mv(32'h0000_0073, 32'h0000_1030, ECALL,   RB, 5'b00000, 5'd0,  5'd0,  5'd0, 32'd0);
        vecs[13] = mv(32'h4052_01B3, 32'h0000_1034, SUB,     AL, 5'b10000, 5'd3,  5'd4,  5'd5, 32'd0);

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_valid_out", 128'(valid_out), 128'd0);
        chk("rst_ready_out", 128'(ready_out), 128'd1);
        chk("rst_name", 128'(instr_name), 128'(UNKNOWN));
        chk("rst_type", 128'(instr_type), 128'(XX));
        chk("rst_flags_regs", {flags, regs}, 128'd0);
        chk("rst_imm_addr", {imm, address_out}, 128'd0);
        step();

        // All vectors, with a stalling downstream on every third word.
        foreach (vecs[i]) send(vecs[i], (i % 3) != 1);
        drain();

        // Three words against a blocked downstream: third must see ready_out low.
        send(vecs[0], 1'b0);
        send(vecs[1], 1'b0);
        valid_in = 1'b1; instr_in = vecs[2].w; address_in = vecs[2].a;
        @(negedge clock);
        chk("bp_ready_low", 128'(ready_out), 128'd0);
        chk("bp_valid_high", 128'(valid_out), 128'd1);
        step();
        send(vecs[2], 1'b1);
        drain();

        // Flush with the buffer full and a word on the input.
        send(vecs[4], 1'b0);
        send(vecs[5], 1'b0);
        flush = 1'b1; valid_in = 1'b1; instr_in = vecs[6].w; address_in = vecs[6].a; ready_in = 1'b0;
        @(negedge clock);
        exp_q.delete();
        step();
        flush = 1'b0; valid_in = 1'b0;
        @(negedge clock);
        chk("flush_valid_low", 128'(valid_out), 128'd0);
        chk("flush_ready_high", 128'(ready_out), 128'd1);
        step();
        send(vecs[13], 1'b1);
        drain();

        // Reset mid-stream with downstream blocked.
        send(vecs[7], 1'b0);
        send(vecs[9], 1'b0);
        reset = 1'b1; valid_in = 1'b1; instr_in = vecs[10].w; address_in = vecs[10].a;
        @(negedge clock);
        exp_q.delete();
        step();
        reset = 1'b0; valid_in = 1'b0;
        @(negedge clock);
        chk("mrst_valid_low", 128'(valid_out), 128'd0);
        chk("mrst_name", 128'(instr_name), 128'(UNKNOWN));
        chk("mrst_ready_high", 128'(ready_out), 128'd1);
        step();
        send(vecs[0], 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required completion within 200000 time units");
        $fatal(1);
    end

endmodule
